// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the handshaking accumulator-CPU control unit:
// stage encoding, 5-bit opcode map and opcode classification helpers.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    STAGE_RESET = 2'b00,
    STAGE_FETCH = 2'b01,
    STAGE_EXEC  = 2'b10,
    STAGE_HALT  = 2'b11
  } stage_t;

  localparam logic [4:0] _HLT  = 5'b00000;
  localparam logic [4:0] _STO  = 5'b00001;
  localparam logic [4:0] _LD   = 5'b00010;
  localparam logic [4:0] _LDI  = 5'b00011;
  localparam logic [4:0] _ADD  = 5'b00100;
  localparam logic [4:0] _ADDI = 5'b00101;
  localparam logic [4:0] _SUB  = 5'b00110;
  localparam logic [4:0] _SUBI = 5'b00111;
  localparam logic [4:0] _BEQ  = 5'b01000;
  localparam logic [4:0] _BNE  = 5'b01001;
  localparam logic [4:0] _BGT  = 5'b01010;
  localparam logic [4:0] _BGE  = 5'b01011;
  localparam logic [4:0] _BLT  = 5'b01100;
  localparam logic [4:0] _BLE  = 5'b01101;
  localparam logic [4:0] _JMP  = 5'b01110;

  // Opcodes that stall in EXEC until the data memory reports completion.
  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == _STO) || (op == _LD) || (op == _ADD) || (op == _SUB);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation for the conditional branch opcodes.
// Non-branch opcodes report not-taken.
module branch_cond
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode_in,
  input  logic       status_Z_in,
  input  logic       status_N_in,
  output logic       taken_out
);

  always_comb begin
    taken_out = 1'b0;
    case (opcode_in)
      _BEQ:    taken_out = status_Z_in;
      _BNE:    taken_out = !status_Z_in;
      _BGT:    taken_out = !status_Z_in && !status_N_in;
      _BGE:    taken_out = !status_N_in;
      _BLT:    taken_out = status_N_in;
      _BLE:    taken_out = status_Z_in || status_N_in;
      default: taken_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit_hs.sv
// Control decoder for the accumulator CPU with memory ready handshakes,
// a resumable HALT stage, illegal-opcode handling and a retirement counter.
module control_unit_hs
  import cpu_ctrl_pkg::*;
#(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int OPCODE_WIDTH      = INSTRUCTION_WIDTH - OPERAND_WIDTH,
  parameter int COUNT_WIDTH       = 16,
  parameter bit TRAP_ILLEGAL      = 1'b0
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic [OPCODE_WIDTH-1:0] opcode_in,
  input  logic                    status_Z_in,
  input  logic                    status_N_in,
  input  logic                    imem_ready_in,
  input  logic                    dmem_ready_in,
  input  logic                    resume_in,
  output logic                    branch_out,
  output logic                    sel_B_out,
  output logic                    alu_op_out,
  output logic [1:0]              sel_A_out,
  output logic                    data_memory_wr_out,
  output logic                    data_memory_rd_out,
  output logic                    acc_wr_out,
  output logic                    pc_wr_out,
  output logic                    status_wr_out,
  output logic                    ir_wr_out,
  output logic                    acc_reset_out,
  output logic                    pc_reset_out,
  output logic                    status_reset_out,
  output logic                    ir_reset_out,
  output logic                    halted_out,
  output logic                    illegal_op_out,
  output logic [COUNT_WIDTH-1:0]  retired_count_out,
  output logic [1:0]              stage_out
);

  if (OPCODE_WIDTH < 5) begin : g_bad_opcode_width
    $error("control_unit_hs: OPCODE_WIDTH must be at least 5");
  end

  stage_t                 stage_q;
  stage_t                 stage_d;
  logic [4:0]             op5;
  logic                   upper_clear;
  logic                   legal;
  logic                   taken;
  logic                   retire;
  logic [COUNT_WIDTH-1:0] count_q;

  assign op5 = opcode_in[4:0];

  // Any set bit above the 5-bit opcode field makes the opcode illegal.
  if (OPCODE_WIDTH > 5) begin : g_upper
    assign upper_clear = ~|opcode_in[OPCODE_WIDTH-1:5];
  end else begin : g_no_upper
    assign upper_clear = 1'b1;
  end

  assign legal = upper_clear && (op5 <= _JMP);

  branch_cond u_branch_cond (
    .opcode_in   (op5),
    .status_Z_in (status_Z_in),
    .status_N_in (status_N_in),
    .taken_out   (taken)
  );

  always_comb begin
    stage_d            = stage_q;
    branch_out         = 1'b0;
    sel_B_out          = 1'b0;
    alu_op_out         = 1'b0;
    sel_A_out          = 2'b00;
    data_memory_wr_out = 1'b0;
    data_memory_rd_out = 1'b0;
    acc_wr_out         = 1'b0;
    pc_wr_out          = 1'b0;
    status_wr_out      = 1'b0;
    ir_wr_out          = 1'b0;
    acc_reset_out      = 1'b0;
    pc_reset_out       = 1'b0;
    status_reset_out   = 1'b0;
    ir_reset_out       = 1'b0;
    halted_out         = 1'b0;
    illegal_op_out     = 1'b0;

    case (stage_q)
      STAGE_RESET: begin
        acc_reset_out    = 1'b1;
        pc_reset_out     = 1'b1;
        status_reset_out = 1'b1;
        ir_reset_out     = 1'b1;
        stage_d          = STAGE_FETCH;
      end

      STAGE_FETCH: begin
        ir_wr_out = imem_ready_in;
        if (imem_ready_in) stage_d = STAGE_EXEC;
      end

      STAGE_EXEC: begin
        if (!legal) begin
          illegal_op_out = 1'b1;
          pc_wr_out      = !TRAP_ILLEGAL;
          stage_d        = TRAP_ILLEGAL ? STAGE_HALT : STAGE_FETCH;
        end else if (op5 == _HLT) begin
          stage_d = STAGE_HALT;
        end else begin
          // Memory-class opcodes hold EXEC until the data memory completes.
          stage_d = (is_mem_op(op5) && !dmem_ready_in) ? STAGE_EXEC : STAGE_FETCH;
          case (op5)
            _STO: begin
              data_memory_wr_out = 1'b1;
              pc_wr_out          = dmem_ready_in;
            end
            _LD: begin
              data_memory_rd_out = 1'b1;
              sel_A_out          = 2'b00;
              acc_wr_out         = dmem_ready_in;
              pc_wr_out          = dmem_ready_in;
            end
            _LDI: begin
              sel_A_out  = 2'b01;
              acc_wr_out = 1'b1;
              pc_wr_out  = 1'b1;
            end
            _ADD, _SUB: begin
              data_memory_rd_out = 1'b1;
              sel_A_out          = 2'b10;
              alu_op_out         = op5[1];
              acc_wr_out         = dmem_ready_in;
              status_wr_out      = dmem_ready_in;
              pc_wr_out          = dmem_ready_in;
            end
            _ADDI, _SUBI: begin
              sel_A_out     = 2'b10;
              sel_B_out     = 1'b1;
              alu_op_out    = op5[1];
              acc_wr_out    = 1'b1;
              status_wr_out = 1'b1;
              pc_wr_out     = 1'b1;
            end
            _BEQ, _BNE, _BGT, _BGE, _BLT, _BLE: begin
              branch_out = taken;
              pc_wr_out  = 1'b1;
            end
            _JMP: begin
              branch_out = 1'b1;
              pc_wr_out  = 1'b1;
            end
            default: stage_d = STAGE_FETCH;
          endcase
        end
      end

      STAGE_HALT: begin
        halted_out = 1'b1;
        pc_wr_out  = resume_in;
        if (resume_in) stage_d = STAGE_FETCH;
      end

      default: begin
        acc_reset_out    = 1'b1;
        pc_reset_out     = 1'b1;
        status_reset_out = 1'b1;
        ir_reset_out     = 1'b1;
        stage_d          = STAGE_RESET;
      end
    endcase
  end

  assign retire = (stage_q == STAGE_EXEC) && (stage_d != STAGE_EXEC);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      stage_q <= STAGE_RESET;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign retired_count_out = count_q;
  assign stage_out         = stage_q;

endmodule

// File: tb/tb_control_unit_hs.sv
// Directed self-checking bench for control_unit_hs: one NOP-on-illegal
// instance with a 4-bit counter and one trapping instance on shared inputs.
module tb_control_unit_hs;
  import cpu_ctrl_pkg::*;

  logic       clock_in;
  logic       reset_in;
  logic [4:0] opcode_in;
  logic       status_Z_in;
  logic       status_N_in;
  logic       imem_ready_in;
  logic       dmem_ready_in;
  logic       resume_in;

  logic       branch_out, sel_B_out, alu_op_out;
  logic [1:0] sel_A_out;
  logic       data_memory_wr_out, data_memory_rd_out;
  logic       acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out;
  logic       acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out;
  logic       halted_out, illegal_op_out;
  logic [3:0] retired_count_out;
  logic [1:0] stage_out;

  logic        trap_branch, trap_sel_B, trap_alu_op;
  logic [1:0]  trap_sel_A;
  logic        trap_dm_wr, trap_dm_rd;
  logic        trap_acc_wr, trap_pc_wr, trap_status_wr, trap_ir_wr;
  logic        trap_acc_rst, trap_pc_rst, trap_status_rst, trap_ir_rst;
  logic        trap_halted, trap_illegal;
  logic [15:0] trap_count;
  logic [1:0]  trap_stage;

  logic [12:0] enables;
  logic [3:0]  resets;
  logic [12:0] trap_enables;
  logic [3:0]  trap_resets;

  int         tests_run;
  int         tests_failed;
  logic [3:0] exp_count;
  logic [15:0] exp_trap_count;
  logic [3:0] branch_mask [6];

  assign enables = {branch_out, sel_B_out, alu_op_out, sel_A_out, data_memory_wr_out,
                    data_memory_rd_out, acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out,
                    halted_out, illegal_op_out};
  assign resets  = {acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out};
  assign trap_enables = {trap_branch, trap_sel_B, trap_alu_op, trap_sel_A, trap_dm_wr,
                         trap_dm_rd, trap_acc_wr, trap_pc_wr, trap_status_wr, trap_ir_wr,
                         trap_halted, trap_illegal};
  assign trap_resets  = {trap_acc_rst, trap_pc_rst, trap_status_rst, trap_ir_rst};

  control_unit_hs #(.COUNT_WIDTH(4), .TRAP_ILLEGAL(1'b0)) u_dut (
    .clock_in(clock_in), .reset_in(reset_in), .opcode_in(opcode_in),
    .status_Z_in(status_Z_in), .status_N_in(status_N_in),
    .imem_ready_in(imem_ready_in), .dmem_ready_in(dmem_ready_in), .resume_in(resume_in),
    .branch_out(branch_out), .sel_B_out(sel_B_out), .alu_op_out(alu_op_out),
    .sel_A_out(sel_A_out), .data_memory_wr_out(data_memory_wr_out),
    .data_memory_rd_out(data_memory_rd_out), .acc_wr_out(acc_wr_out),
    .pc_wr_out(pc_wr_out), .status_wr_out(status_wr_out), .ir_wr_out(ir_wr_out),
    .acc_reset_out(acc_reset_out), .pc_reset_out(pc_reset_out),
    .status_reset_out(status_reset_out), .ir_reset_out(ir_reset_out),
    .halted_out(halted_out), .illegal_op_out(illegal_op_out),
    .retired_count_out(retired_count_out), .stage_out(stage_out)
  );

  control_unit_hs #(.TRAP_ILLEGAL(1'b1)) u_trap (
    .clock_in(clock_in), .reset_in(reset_in), .opcode_in(opcode_in),
    .status_Z_in(status_Z_in), .status_N_in(status_N_in),
    .imem_ready_in(imem_ready_in), .dmem_ready_in(dmem_ready_in), .resume_in(resume_in),
    .branch_out(trap_branch), .sel_B_out(trap_sel_B), .alu_op_out(trap_alu_op),
    .sel_A_out(trap_sel_A), .data_memory_wr_out(trap_dm_wr),
    .data_memory_rd_out(trap_dm_rd), .acc_wr_out(trap_acc_wr),
    .pc_wr_out(trap_pc_wr), .status_wr_out(trap_status_wr), .ir_wr_out(trap_ir_wr),
    .acc_reset_out(trap_acc_rst), .pc_reset_out(trap_pc_rst),
    .status_reset_out(trap_status_rst), .ir_reset_out(trap_ir_rst),
    .halted_out(trap_halted), .illegal_op_out(trap_illegal),
    .retired_count_out(trap_count), .stage_out(trap_stage)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clock_in);
    #1;
  endtask

  task automatic applyStimulus(input logic z, input logic n, input logic dmem,
                               input logic resume);
    status_Z_in   = z;
    status_N_in   = n;
    dmem_ready_in = dmem;
    resume_in     = resume;
    #1;
  endtask

  // Present an opcode in FETCH with the instruction memory ready; returns in EXEC.
  task automatic fetchOp(input logic [4:0] op);
    opcode_in     = op;
    imem_ready_in = 1'b1;
    dmem_ready_in = 1'b0;
    resume_in     = 1'b0;
    #1;
    checkOutput("fetch_stage", stage_out, 2'b01);
    checkOutput("fetch_ir_wr", ir_wr_out, 1'b1);
    stepClock();
    imem_ready_in = 1'b0;
  endtask

  task automatic retireStep();
    stepClock();
    exp_count++;
    exp_trap_count++;
    checkOutput("retired_count", retired_count_out, exp_count);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    exp_count      = '0;
    exp_trap_count = '0;
    // Taken mask indexed by {Z,N}, order BEQ BNE BGT BGE BLT BLE.
    branch_mask[0] = 4'b1100;
    branch_mask[1] = 4'b0011;
    branch_mask[2] = 4'b0001;
    branch_mask[3] = 4'b0101;
    branch_mask[4] = 4'b1010;
    branch_mask[5] = 4'b1110;

    reset_in      = 1'b1;
    opcode_in     = _HLT;
    status_Z_in   = 1'b0;
    status_N_in   = 1'b0;
    imem_ready_in = 1'b1;
    dmem_ready_in = 1'b0;
    resume_in     = 1'b0;

    repeat (3) stepClock();
    checkOutput("reset_hold_stage", stage_out, 2'b00);
    checkOutput("reset_hold_count", retired_count_out, 4'd0);
    reset_in = 1'b0;
    #1;
    checkOutput("reset_release_stage", stage_out, 2'b00);
    checkOutput("reset_release_resets", resets, 4'hF);
    checkOutput("reset_release_enables", enables, 13'h0);
    stepClock();
    checkOutput("after_reset_stage", stage_out, 2'b01);
    checkOutput("after_reset_resets", resets, 4'h0);
    checkOutput("after_reset_count", retired_count_out, 4'd0);

    fetchOp(_LD);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, (i == 2), 1'b0);
      checkOutput("ld_stage", stage_out, 2'b10);
      checkOutput("ld_rd", data_memory_rd_out, 1'b1);
      checkOutput("ld_acc_wr", acc_wr_out, (i == 2));
      checkOutput("ld_pc_wr", pc_wr_out, (i == 2));
      checkOutput("ld_count_hold", retired_count_out, exp_count);
      if (i < 2) stepClock();
    end
    retireStep();
    checkOutput("ld_next_stage", stage_out, 2'b01);

    fetchOp(_ADD);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("add_wait_sel", {sel_A_out, status_wr_out, pc_wr_out}, 4'b1000);
    stepClock();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("add_done", {sel_A_out, sel_B_out, alu_op_out, data_memory_rd_out,
                             acc_wr_out, status_wr_out, pc_wr_out}, 8'b10001111);
    retireStep();

    fetchOp(_SUBI);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("subi", {sel_A_out, sel_B_out, alu_op_out, data_memory_rd_out,
                         acc_wr_out, status_wr_out, pc_wr_out}, 8'b10110111);
    retireStep();

    for (int b = 0; b < 6; b++) begin
      for (int zn = 0; zn < 4; zn++) begin
        fetchOp(_BEQ + 5'(b));
        applyStimulus(zn[1], zn[0], 1'b0, 1'b0);
        checkOutput($sformatf("branch_op%0d_zn%0d", b, zn), branch_out, branch_mask[b][zn]);
        checkOutput("branch_pc_wr", pc_wr_out, 1'b1);
        retireStep();
      end
    end

    for (int zn = 0; zn < 4; zn++) begin
      fetchOp(_JMP);
      applyStimulus(zn[1], zn[0], 1'b0, 1'b0);
      checkOutput("jmp_branch_pc", {branch_out, pc_wr_out}, 2'b11);
      retireStep();
    end

    fetchOp(_HLT);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hlt_exec_enables", enables, 13'h0);
    retireStep();
    for (int i = 0; i < 5; i++) begin
      checkOutput("halt_stage", stage_out, 2'b11);
      checkOutput("halt_halted", halted_out, 1'b1);
      checkOutput("halt_pc_wr", pc_wr_out, 1'b0);
      stepClock();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("resume_pc_wr", {halted_out, pc_wr_out, stage_out}, 4'b1111);
    stepClock();
    resume_in = 1'b0;
    #1;
    checkOutput("resume_next_stage", stage_out, 2'b01);
    checkOutput("resume_count", retired_count_out, exp_count);
    checkOutput("resume_trap_count", trap_count, exp_trap_count);

    fetchOp(5'b10110);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("illegal_nop", {illegal_op_out, pc_wr_out}, 2'b11);
    checkOutput("illegal_trap", {trap_illegal, trap_pc_wr}, 2'b10);
    retireStep();
    checkOutput("illegal_nop_stage", {stage_out, illegal_op_out}, 3'b010);
    checkOutput("illegal_trap_stage", {trap_stage, trap_illegal}, 3'b110);
    checkOutput("illegal_trap_enables", trap_enables, 13'h2);
    checkOutput("illegal_trap_count", trap_count, exp_trap_count);

    fetchOp(_STO);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sto_wait", {data_memory_wr_out, pc_wr_out}, 2'b10);
    stepClock();
    checkOutput("sto_still_exec", stage_out, 2'b10);
    reset_in = 1'b1;
    #1;
    checkOutput("midwait_reset_stage", stage_out, 2'b00);
    checkOutput("midwait_reset_wr", data_memory_wr_out, 1'b0);
    checkOutput("midwait_reset_count", retired_count_out, 4'd0);
    checkOutput("midwait_trap_resets", trap_resets, 4'hF);
    stepClock();
    reset_in = 1'b0;
    stepClock();
    exp_count      = '0;
    exp_trap_count = '0;

    for (int i = 0; i < 17; i++) begin
      fetchOp(_LDI);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ldi", {sel_A_out, acc_wr_out, pc_wr_out, data_memory_rd_out}, 5'b01110);
      retireStep();
    end
    checkOutput("wrap_count", retired_count_out, 4'd1);
    checkOutput("wide_count", trap_count, 16'd17);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_unit_hs.md
Name: control_unit_hs

Overview:
- Parametrised successor to the accumulator CPU's control decoder. Sits between the instruction register opcode field, the status flags and all datapath enables.
- Adds several features:
  - ready handshakes to instruction and data memory (wait states);
  - a real HALT state with resume;
  - configurable illegal-opcode handling;
  - a retired-instruction counter.
- Stage sequence is RESET -> FETCH -> EXEC -> FETCH..., with HALT entered from EXEC.

Parameters:
- OPERAND_WIDTH, 11, operand field width.
- INSTRUCTION_WIDTH, 16, instruction width.
- OPCODE_WIDTH, INSTRUCTION_WIDTH-OPERAND_WIDTH, opcode width. Must be >= 5; elaboration error otherwise.
- COUNT_WIDTH, 16, width of the retired-instruction counter.
- TRAP_ILLEGAL, 0, illegal-opcode mode:
  - 0: illegal opcode executes as NOP and flags it.
  - 1: illegal opcode halts.

Ports:
- clock_in  in  1  single clock; all state changes on the rising edge.
- reset_in  in  1  asynchronous reset, active-high.
- opcode_in  in  OPCODE_WIDTH  opcode from the IR.
- status_Z_in, status_N_in  in  1 each  zero and negative flags.
- imem_ready_in  in  1  instruction memory data valid this cycle.
- dmem_ready_in  in  1  data memory access completes this cycle.
- resume_in  in  1  leave HALT.
- branch_out, sel_B_out, alu_op_out  out  1 each  datapath selects (ISA encoding unchanged).
- sel_A_out  out  2  accumulator source select: 00 memory, 01 immediate, 10 ALU.
- data_memory_wr_out, data_memory_rd_out  out  1 each  data memory write and read request.
- acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out  out  1 each  register write enables.
- acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out  out  1 each  register resets.
- halted_out  out  1  high while in HALT.
- illegal_op_out  out  1  one-cycle pulse on illegal-opcode retirement or trap.
- retired_count_out  out  COUNT_WIDTH  count of retired instructions.
- stage_out  out  2  current stage: RESET=00, FETCH=01, EXEC=10, HALT=11.

Behaviour:
- Reset:
  - While reset_in=1 the stage is forced to RESET asynchronously and retired_count is cleared to 0.
  - In RESET, the four *_reset_out are 1 and every other output is 0 (stage_out=00).
  - After reset_in falls, RESET lasts exactly one clock, then the stage moves to FETCH.
  - Reset asserted in any stage, including mid-wait, aborts immediately with no writes.
- FETCH:
  - ir_wr_out = imem_ready_in; all other outputs are 0.
  - Move to EXEC on an edge where imem_ready_in=1; otherwise stay in FETCH (unbounded wait).
- EXEC, common rules:
  - Outputs are Mealy on opcode_in, the flags and dmem_ready_in.
  - ir_wr_out=0 and all *_reset_out=0.
  - An instruction retires on the edge that leaves EXEC. retired_count increments by 1 at retirement and wraps modulo 2^COUNT_WIDTH.
- EXEC, per opcode (opcode bits above bit 4 must be zero, otherwise the opcode is illegal):
  - HLT (00000): all enables 0; next stage HALT; counts as retired.
  - STO (00001): data_memory_wr_out=1 for the whole stay. pc_wr_out = dmem_ready_in. Stay in EXEC until dmem_ready_in=1.
  - LD (00010): data_memory_rd_out=1, sel_A=00. acc_wr_out and pc_wr_out = dmem_ready_in. Stay until ready.
  - LDI (00011): sel_A=01; acc_wr_out=1 and pc_wr_out=1; one cycle; no memory access.
  - ADD/SUB (00100/00110): data_memory_rd_out=1, sel_A=10, sel_B=0, alu_op=0 for ADD and 1 for SUB. acc_wr_out, status_wr_out and pc_wr_out = dmem_ready_in. Stay until ready.
  - ADDI/SUBI (00101/00111): same as ADD/SUB with sel_B=1, no memory read, one cycle.
  - Branches 01000-01101 (BEQ, BNE, BGT, BGE, BLT, BLE): pc_wr_out=1; branch_out = condition. Conditions:
    - BEQ: Z
    - BNE: !Z
    - BGT: !Z & !N
    - BGE: !N
    - BLT: N
    - BLE: Z | N
    - Branches take one cycle.
  - JMP (01110): branch_out=1, pc_wr_out=1; one cycle.
  - Illegal opcode, TRAP_ILLEGAL=0: executes as NOP with pc_wr_out=1; illegal_op_out=1 for that cycle; goes to FETCH; counts as retired.
  - Illegal opcode, TRAP_ILLEGAL=1: pc_wr_out=0; illegal_op_out=1; goes to HALT; counts as retired.
- Memory waits: flag changes during a memory wait do not matter, because flags are only consumed by branches, which never wait.
- HALT:
  - halted_out=1; all enables 0 except pc_wr_out = resume_in, so the PC steps past HLT or the trapping opcode.
  - On an edge with resume_in=1, move to FETCH. If resume_in is held high it is only acted on once, because the stage leaves HALT.
  - Resuming does not retire an instruction.
- Stage encoding: an unreachable stage code goes to RESET on the next clock, with RESET outputs driven.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the stage_t enum (4 codes above);
  - the opcode localparams _HLT.._JMP (5-bit);
  - an is_mem_op function covering STO, LD, ADD, SUB.
- Sub-module branch_cond (combinational): takes opcode_in[4:0], status_Z_in and status_N_in, and produces a taken signal.
- The top level holds the stage register, the counter and the output decode.

Test Plan:
- Reset and fetch: assert reset_in for 3 cycles with imem_ready_in=1, then release. Expect:
  - RESET outputs (four *_reset_out=1, stage_out=00) for 1 cycle after release;
  - then FETCH with ir_wr_out=1;
  - retired_count_out=0.
- LD with 2 wait states: opcode 00010 with dmem_ready_in 0,0,1. Expect:
  - data_memory_rd_out=1 for 3 cycles;
  - acc_wr_out and pc_wr_out high only in the 3rd cycle;
  - count increments by 1 after that cycle.
- Branch matrix: each of BEQ..BLE across all 4 combinations of (Z,N). Expect branch_out per the condition table and pc_wr_out=1 in every case. JMP always gives branch_out=1.
- HLT then resume: opcode 00000, hold resume_in=0 for 5 cycles, then 1 for 1 cycle. Expect:
  - halted_out=1 and stage_out=11 throughout HALT;
  - pc_wr_out=1 in the resume cycle only;
  - next stage FETCH;
  - count +1 total.
- Illegal opcode 10110:
  - With TRAP_ILLEGAL=0: one illegal_op_out pulse, pc_wr_out=1, return to FETCH.
  - With TRAP_ILLEGAL=1: one pulse, pc_wr_out=0, stage_out=11.
- Reset mid-wait and counter wrap:
  - Assert reset_in during a STO wait; expect an immediate RESET stage with data_memory_wr_out=0.
  - With COUNT_WIDTH=4, retire 17 LDI instructions; expect retired_count_out=1.
